// File: rtl/mandelbrot_example_axi_write_master.sv
// mandelbrot_example_axi_write_master
// Streams AXI4-Stream beats into memory as AXI4 INCR write bursts. One
// command produces ceil(length/C_BURST_LEN) bursts; ctrl_done pulses after
// the last write response. Optional feature macro: MANDELBROT_WR_BRESP_CHECK_EN
// adds bresp input and sticky ctrl_error output.
module mandelbrot_example_axi_write_master #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = 256,
  parameter int C_LOG_BURST_LEN   = 8,
  parameter int C_MAX_OUTSTANDING = 3
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic                        ctrl_start,
  output logic                        ctrl_done,
  input  logic [C_ADDR_WIDTH-1:0]     ctrl_offset,
  input  logic [C_LENGTH_WIDTH-1:0]   ctrl_length,
`ifdef MANDELBROT_WR_BRESP_CHECK_EN
  input  logic [1:0]                  bresp,
  output logic                        ctrl_error,
`endif
  output logic                        awvalid,
  input  logic                        awready,
  output logic [C_ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic                        wvalid,
  input  logic                        wready,
  output logic [C_DATA_WIDTH-1:0]     wdata,
  output logic [C_DATA_WIDTH/8-1:0]   wstrb,
  output logic                        wlast,
  input  logic                        bvalid,
  output logic                        bready,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [C_DATA_WIDTH-1:0]     s_tdata
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int CNT_W  = C_LENGTH_WIDTH - C_LOG_BURST_LEN + 1;
  localparam int LEN_W  = C_LOG_BURST_LEN + 1;
  localparam int OUT_W  = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int AWSIZE = $clog2(STRB_W);
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP = C_ADDR_WIDTH'(C_BURST_LEN * STRB_W);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                      awvalid_q, awvalid_d;
  logic [7:0]                awlen_q, awlen_d;
  logic [CNT_W-1:0]          bursts_total_q, bursts_total_d;
  logic [CNT_W-1:0]          aw_to_go_q, aw_to_go_d;
  logic [CNT_W-1:0]          b_done_q, b_done_d;
  logic [CNT_W-1:0]          w_bursts_q, w_bursts_d;
  logic [LEN_W-1:0]          final_len_q, final_len_d;
  logic [LEN_W-1:0]          beat_q, beat_d;
  logic [OUT_W-1:0]          outstanding_q, outstanding_d;
  logic [OUT_W-1:0]          w_pending_q, w_pending_d;

  // Command decode: burst count rounds up, last burst length wraps 0 to a full burst.
  logic [C_LENGTH_WIDTH:0]   len_round_s;
  logic [CNT_W-1:0]          bursts_init_s;
  logic [LEN_W-1:0]          final_init_s;
  logic                      len_zero_s;
  logic                      start_acc_s;
  assign len_round_s   = {1'b0, ctrl_length} + (C_LENGTH_WIDTH+1)'(C_BURST_LEN - 1);
  assign bursts_init_s = len_round_s[C_LENGTH_WIDTH:C_LOG_BURST_LEN];
  assign final_init_s  = (ctrl_length[C_LOG_BURST_LEN-1:0] == C_LOG_BURST_LEN'(0)) ?
                         LEN_W'(C_BURST_LEN) : {1'b0, ctrl_length[C_LOG_BURST_LEN-1:0]};
  assign len_zero_s    = (ctrl_length == C_LENGTH_WIDTH'(0));
  assign start_acc_s   = ctrl_start && (state_q == ST_IDLE);

  // Channel events; W may only flow while an issued burst still owes beats.
  logic w_open_s, aw_fire_s, w_fire_s, wlast_fire_s, b_fire_s, last_b_s;
  logic [LEN_W-1:0] cur_len_s;
  assign w_open_s     = (w_pending_q != OUT_W'(0));
  assign cur_len_s    = (w_bursts_q == bursts_total_q - CNT_W'(1)) ? final_len_q : LEN_W'(C_BURST_LEN);
  assign aw_fire_s    = awvalid_q && awready;
  assign w_fire_s     = s_tvalid && wready && w_open_s;
  assign wlast_fire_s = w_fire_s && wlast;
  assign b_fire_s     = bvalid && bready;
  assign last_b_s     = b_fire_s && ((b_done_q + CNT_W'(1)) == bursts_total_q);

  assign awvalid  = awvalid_q;
  assign awaddr   = addr_q;
  assign awlen    = awlen_q;
  assign awsize   = 3'(AWSIZE);
  assign wvalid   = s_tvalid && w_open_s;
  assign s_tready = wready && w_open_s;
  assign wdata    = s_tdata;
  assign wstrb    = {STRB_W{1'b1}};
  assign wlast    = w_open_s && (beat_q == cur_len_s - LEN_W'(1));

  // State register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic: zero-length commands skip straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) state_d = len_zero_s ? ST_DONE : ST_RUN;
        else            state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_b_s) state_d = ST_DONE;
        else          state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    ctrl_done = 1'b0;
    bready    = 1'b0;
    case (state_q)
      ST_RUN:  bready    = 1'b1;
      ST_DONE: ctrl_done = 1'b1;
      default: begin
        ctrl_done = 1'b0;
        bready    = 1'b0;
      end
    endcase
  end

  // Datapath next state: AW issue, burst/beat bookkeeping, response counting.
  always_comb begin
    addr_d         = addr_q;
    awvalid_d      = awvalid_q;
    awlen_d        = awlen_q;
    bursts_total_d = bursts_total_q;
    final_len_d    = final_len_q;
    aw_to_go_d     = aw_to_go_q;
    b_done_d       = b_done_q;
    w_bursts_d     = w_bursts_q;
    beat_d         = beat_q;
    outstanding_d  = outstanding_q;
    w_pending_d    = w_pending_q;
    if (start_acc_s) begin
      addr_d         = ctrl_offset;
      awvalid_d      = 1'b0;
      bursts_total_d = bursts_init_s;
      final_len_d    = final_init_s;
      aw_to_go_d     = bursts_init_s;
      b_done_d       = CNT_W'(0);
      w_bursts_d     = CNT_W'(0);
      beat_d         = LEN_W'(0);
      outstanding_d  = OUT_W'(0);
      w_pending_d    = OUT_W'(0);
    end else if (state_q == ST_RUN) begin
      // awvalid drops for at least one cycle after each acceptance
      if (awvalid_q) begin
        awvalid_d = ~awready;
      end else if ((aw_to_go_q != CNT_W'(0)) &&
                   (outstanding_q < OUT_W'(C_MAX_OUTSTANDING))) begin
        awvalid_d = 1'b1;
        awlen_d   = (aw_to_go_q == CNT_W'(1)) ? 8'(final_len_q - LEN_W'(1)) : 8'(C_BURST_LEN - 1);
      end else begin
        awvalid_d = 1'b0;
      end
      if (aw_fire_s) begin
        addr_d     = addr_q + ADDR_STEP;
        aw_to_go_d = aw_to_go_q - CNT_W'(1);
      end else begin
        addr_d     = addr_q;
      end
      case ({aw_fire_s, b_fire_s})
        2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
        2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
        default: outstanding_d = outstanding_q;
      endcase
      case ({aw_fire_s, wlast_fire_s})
        2'b10:   w_pending_d = w_pending_q + OUT_W'(1);
        2'b01:   w_pending_d = w_pending_q - OUT_W'(1);
        default: w_pending_d = w_pending_q;
      endcase
      if (wlast_fire_s) begin
        beat_d     = LEN_W'(0);
        w_bursts_d = w_bursts_q + CNT_W'(1);
      end else if (w_fire_s) begin
        beat_d     = beat_q + LEN_W'(1);
      end else begin
        beat_d     = beat_q;
      end
      if (b_fire_s) b_done_d = b_done_q + CNT_W'(1);
      else          b_done_d = b_done_q;
    end else begin
      awvalid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      addr_q         <= C_ADDR_WIDTH'(0);
      awvalid_q      <= 1'b0;
      awlen_q        <= 8'd0;
      bursts_total_q <= CNT_W'(0);
      final_len_q    <= LEN_W'(0);
      aw_to_go_q     <= CNT_W'(0);
      b_done_q       <= CNT_W'(0);
      w_bursts_q     <= CNT_W'(0);
      beat_q         <= LEN_W'(0);
      outstanding_q  <= OUT_W'(0);
      w_pending_q    <= OUT_W'(0);
    end else begin
      addr_q         <= addr_d;
      awvalid_q      <= awvalid_d;
      awlen_q        <= awlen_d;
      bursts_total_q <= bursts_total_d;
      final_len_q    <= final_len_d;
      aw_to_go_q     <= aw_to_go_d;
      b_done_q       <= b_done_d;
      w_bursts_q     <= w_bursts_d;
      beat_q         <= beat_d;
      outstanding_q  <= outstanding_d;
      w_pending_q    <= w_pending_d;
    end
  end

`ifdef MANDELBROT_WR_BRESP_CHECK_EN
  logic error_q, error_d;
  assign ctrl_error = error_q;

  // Sticky error flag: set by any non-OKAY response, cleared by a new command.
  always_comb begin
    if (start_acc_s)                          error_d = 1'b0;
    else if (b_fire_s && (bresp != 2'b00))    error_d = 1'b1;
    else                                      error_d = error_q;
  end

  // Error flag register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) error_q <= 1'b0;
    else           error_q <= error_d;
  end
`endif

endmodule
